he_lut_update_ctrl: RTL and testbench
=====================================

Name: he_lut_update_ctrl

Overview:
- Frame-level sequencer for the histogram-equalisation path; sits between histogram_statistics, the CDF/mapping pipeline and a ping-pong pair of mapping-LUT RAM banks.
- Decides when a finished histogram is read out.
- Counts mapping-table writes into the shadow bank.
- Swaps shadow and active banks only at a frame boundary, so the pixel stream never sees a half-written table.
- Also owns the bypass decision (equalisation off, or no valid table yet).

Parameters:
LEVELS, 256, number of grey levels (entries per LUT bank)
CNT_W, 9, width of the write counter (must hold LEVELS)
UPD_INTERVAL, 1, LUT refreshed every N frames (1 = every frame); range 1..255
TIMEOUT, 1024, max idle cycles between map writes while filling before abort
TO_W, 11, timeout counter width

Ports:
pclk  in  1  pixel clock
rst_n  in  1  asynchronous, active-low reset
src_vsync  in  1  source frame-active (high during frame; rise = SOF, fall = EOF)
he_en  in  1  equalisation enable request (sampled only at SOF)
stat_ready  in  1  one-cycle pulse: histogram result ready for readout
stat_request  out  1  one-cycle pulse: start histogram readout
map_wr_en  in  1  mapping-pipeline write strobe (one per grey level, ascending order)
wr_bank  out  1  bank index the mapping pipeline writes (shadow)
rd_bank  out  1  bank index the pixel LUT reads (active)
lut_valid  out  1  at least one complete table has been swapped in
bypass  out  1  output mux selects raw pixel
upd_busy  out  1  update in progress (state != IDLE)
err_overrun  out  1  one-cycle pulse: stat_ready dropped (busy or not an update frame)
err_timeout  out  1  one-cycle pulse: fill aborted

Behaviour:
- Reset values: stat_request=0, wr_bank=0, rd_bank=1, lut_valid=0, bypass=1, upd_busy=0, err_* = 0, state=IDLE, counters=0, upd_slot=0.
- Async reset mid-update discards the partial table. lut_valid returns to 0.
- Edge detect: src_vsync registered once. SOF/EOF are decoded one cycle after the input edge.
- Frame phase counter ph: increments at each EOF and wraps at UPD_INTERVAL-1. At EOF, upd_slot <= (ph==0); it is cleared on acceptance or at the next EOF.
- State IDLE:
  - stat_ready && upd_slot: register stat_request=1 for exactly 1 cycle, clear wcnt and tocnt, go to FILL, clear upd_slot.
  - stat_ready && !upd_slot: err_overrun pulse, stay IDLE.
- State FILL:
  - Each map_wr_en: wcnt+1, tocnt cleared.
  - map_wr_en while wcnt==LEVELS-1: go to PEND.
  - Otherwise tocnt+1. tocnt==TIMEOUT-1 without a write: err_timeout pulse, go to IDLE. Banks and lut_valid unchanged.
  - stat_ready in FILL: err_overrun, ignored.
- State PEND:
  - On SOF: rd_bank <= wr_bank, wr_bank <= ~wr_bank, lut_valid <= 1, go to IDLE.
  - stat_ready in PEND: err_overrun.
  - EOF before SOF is impossible by protocol; ignore it.
- Completion cycle coinciding with SOF: the swap waits for the following SOF (PEND is entered first).
- wr_bank always differs from rd_bank, and both change only in the swap cycle.
- bypass is updated only at SOF: bypass <= !(he_en && lut_valid_next), where lut_valid_next includes a swap in the same cycle. It is constant for the whole frame.
- map_wr_en outside FILL: ignored, with no error. The datapath gates RAM writes with upd_busy.
- upd_busy = (state != IDLE), combinational from the state register.

Decomposition:
- Shared package he_pkg:
  - LEVELS, CNT_W, and the state encoding (IDLE=2'd0, FILL=2'd1, PEND=2'd2).
  - An SOF/EOF edge-detect function or constant used by the other equalisation blocks.
- One natural sub-module: he_frame_sync. It takes src_vsync and produces sof and eof pulses plus the ph/upd_slot logic, and is reusable by the statistics block. The FSM stays in the top.

Test Plan:
- Reset, then 3 frames (UPD_INTERVAL=1), 256 map_wr_en after each stat_ready:
  - stat_request pulses 1 cycle after each stat_ready.
  - At 1st SOF after the fill: rd_bank 1->0, wr_bank 0->1, lut_valid=1.
  - bypass=0 from that SOF (he_en=1).
- Fill with 255 writes then silence for 1024 cycles: err_timeout pulse; banks unchanged; lut_valid stays 0; bypass stays 1.
- UPD_INTERVAL=3, stat_ready after frames 1..6: accepted after frames 1 and 4; err_overrun after 2, 3, 5, 6.
- stat_ready during FILL at write 100: err_overrun pulse; the fill completes normally at write 256.
- 256th write in the same cycle as decoded SOF: no swap that frame; swap at the next SOF.
- he_en dropped mid-frame with a valid table: bypass stays 0 until the next SOF, then 1.
- rst_n low at write 128: all outputs return to reset values immediately; a new cycle works from IDLE.

Source files
------------

// File: rtl/he_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : he_pkg
//  Purpose  : Shared constants, FSM encoding and frame edge-detect helper
//             for the histogram-equalisation blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package he_pkg;

  localparam int LEVELS = 256;
  localparam int CNT_W  = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PEND = 2'd2
  } he_state_e;

  typedef struct packed {
    logic sof;
    logic eof;
  } he_edge_t;

  // Rising edge of frame-active is SOF, falling edge is EOF
  function automatic he_edge_t he_edge_detect(input logic cur, input logic prev);
    he_edge_t e;
    e.sof = cur & ~prev;
    e.eof = ~cur & prev;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/he_frame_sync.sv
`default_nettype none
// ============================================================================
//  Module   : he_frame_sync
//  Purpose  : Registered SOF/EOF pulses from src_vsync, frame phase counter
//             and the "this frame's histogram may be taken" slot flag.
//  Revision : 1.0 - initial release
// ============================================================================
module he_frame_sync #(
  parameter int UPD_INTERVAL = 1,
  parameter int PH_W         = 8
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic src_vsync,
  input  logic accept,
  output logic sof,
  output logic eof,
  output logic upd_slot
);
  import he_pkg::*;

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(UPD_INTERVAL - 1);

  logic            vs_q, vs_d;
  logic            sof_q, sof_d;
  logic            eof_q, eof_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic            upd_slot_q, upd_slot_d;
  he_edge_t        vs_edge;

  assign vs_edge = he_edge_detect(src_vsync, vs_q);

  // Next-state: edge pulses, phase wrap at EOF, slot set at EOF / cleared on accept
  always_comb begin
    vs_d       = src_vsync;
    sof_d      = vs_edge.sof;
    eof_d      = vs_edge.eof;
    ph_d       = ph_q;
    upd_slot_d = upd_slot_q;
    if (eof_q) begin
      upd_slot_d = (ph_q == '0);
      ph_d       = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
    end else if (accept) begin
      upd_slot_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q       <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      ph_q       <= '0;
      upd_slot_q <= 1'b0;
    end else begin
      vs_q       <= vs_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      ph_q       <= ph_d;
      upd_slot_q <= upd_slot_d;
    end
  end

  assign sof      = sof_q;
  assign eof      = eof_q;
  assign upd_slot = upd_slot_q;

endmodule
`default_nettype wire

// File: rtl/he_lut_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : he_lut_update_ctrl
//  Purpose  : Frame-level sequencer for the HE path: histogram readout
//             request, shadow-bank fill tracking, frame-aligned ping-pong
//             bank swap and bypass decision.
//  Revision : 1.0 - initial release
// ============================================================================
module he_lut_update_ctrl #(
  parameter int LEVELS       = he_pkg::LEVELS,
  parameter int CNT_W        = he_pkg::CNT_W,
  parameter int UPD_INTERVAL = 1,
  parameter int TIMEOUT      = 1024,
  parameter int TO_W         = 11
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic src_vsync,
  input  logic he_en,
  input  logic stat_ready,
  output logic stat_request,
  input  logic map_wr_en,
  output logic wr_bank,
  output logic rd_bank,
  output logic lut_valid,
  output logic bypass,
  output logic upd_busy,
  output logic err_overrun,
  output logic err_timeout
);
  import he_pkg::*;

  localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(LEVELS - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

  logic             sof;
  logic             eof_unused;  // PEND waits on SOF only; EOF has no role here
  logic             upd_slot;
  logic             accept;

  he_state_e        state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [TO_W-1:0]  tocnt_q, tocnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic             lut_valid_q, lut_valid_d;
  logic             bypass_q, bypass_d;
  logic             stat_request_q, stat_request_d;
  logic             err_overrun_q, err_overrun_d;
  logic             err_timeout_q, err_timeout_d;

  he_frame_sync #(
    .UPD_INTERVAL (UPD_INTERVAL)
  ) u_frame_sync (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .src_vsync (src_vsync),
    .accept    (accept),
    .sof       (sof),
    .eof       (eof_unused),
    .upd_slot  (upd_slot)
  );

  // Update FSM: readout request, fill counting/timeout, frame-aligned swap, bypass
  always_comb begin
    state_d        = state_q;
    wcnt_d         = wcnt_q;
    tocnt_d        = tocnt_q;
    wr_bank_d      = wr_bank_q;
    lut_valid_d    = lut_valid_q;
    bypass_d       = bypass_q;
    stat_request_d = 1'b0;
    err_overrun_d  = 1'b0;
    err_timeout_d  = 1'b0;
    accept         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (stat_ready) begin
          if (upd_slot) begin
            stat_request_d = 1'b1;
            wcnt_d         = '0;
            tocnt_d        = '0;
            accept         = 1'b1;
            state_d        = ST_FILL;
          end else begin
            err_overrun_d  = 1'b1;
          end
        end
      end
      ST_FILL: begin
        err_overrun_d = stat_ready;
        if (map_wr_en) begin
          wcnt_d  = wcnt_q + 1'b1;
          tocnt_d = '0;
          if (wcnt_q == WCNT_LAST) begin
            state_d = ST_PEND;
          end
        end else if (tocnt_q == TO_LAST) begin
          // Abandon the partial table; active bank keeps serving
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          tocnt_d = tocnt_q + 1'b1;
        end
      end
      ST_PEND: begin
        err_overrun_d = stat_ready;
        if (sof) begin
          wr_bank_d   = ~wr_bank_q;
          lut_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bypass is frame-constant and sees a swap happening in the same SOF cycle
    if (sof) begin
      bypass_d = ~(he_en & lut_valid_d);
    end
  end

  // State registers; reset discards any partial table
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      wcnt_q         <= '0;
      tocnt_q        <= '0;
      wr_bank_q      <= 1'b0;
      lut_valid_q    <= 1'b0;
      bypass_q       <= 1'b1;
      stat_request_q <= 1'b0;
      err_overrun_q  <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      tocnt_q        <= tocnt_d;
      wr_bank_q      <= wr_bank_d;
      lut_valid_q    <= lut_valid_d;
      bypass_q       <= bypass_d;
      stat_request_q <= stat_request_d;
      err_overrun_q  <= err_overrun_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  // Read bank is always the complement of the write bank
  assign wr_bank      = wr_bank_q;
  assign rd_bank      = ~wr_bank_q;
  assign lut_valid    = lut_valid_q;
  assign bypass       = bypass_q;
  assign upd_busy     = (state_q != ST_IDLE);
  assign stat_request = stat_request_q;
  assign err_overrun  = err_overrun_q;
  assign err_timeout  = err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_he_lut_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_he_lut_update_ctrl
//  Purpose  : Self-checking bench; two instances (refresh every frame and
//             every third frame) share one stimulus stream and are compared
//             each cycle against a frame-level behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_he_lut_update_ctrl;

  localparam int LV = 256;
  localparam int TO = 1024;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic src_vsync = 1'b0;
  logic he_en = 1'b0;
  logic stat_ready = 1'b0;
  logic map_wr_en = 1'b0;
  logic [1:0] stat_request, wr_bank, rd_bank, lut_valid, bypass, upd_busy, err_overrun, err_timeout;

  always #5 pclk = ~pclk;

  he_lut_update_ctrl #(.UPD_INTERVAL(1)) u_dut1 (
    .pclk(pclk), .rst_n(rst_n), .src_vsync(src_vsync), .he_en(he_en),
    .stat_ready(stat_ready), .stat_request(stat_request[0]), .map_wr_en(map_wr_en),
    .wr_bank(wr_bank[0]), .rd_bank(rd_bank[0]), .lut_valid(lut_valid[0]),
    .bypass(bypass[0]), .upd_busy(upd_busy[0]), .err_overrun(err_overrun[0]),
    .err_timeout(err_timeout[0]));

  he_lut_update_ctrl #(.UPD_INTERVAL(3)) u_dut3 (
    .pclk(pclk), .rst_n(rst_n), .src_vsync(src_vsync), .he_en(he_en),
    .stat_ready(stat_ready), .stat_request(stat_request[1]), .map_wr_en(map_wr_en),
    .wr_bank(wr_bank[1]), .rd_bank(rd_bank[1]), .lut_valid(lut_valid[1]),
    .bypass(bypass[1]), .upd_busy(upd_busy[1]), .err_overrun(err_overrun[1]),
    .err_timeout(err_timeout[1]));

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt[2] = '{0, 0};
  int ovr_cnt[2] = '{0, 0};
  int tmo_cnt[2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] outs(input int i);
    return {stat_request[i], wr_bank[i], rd_bank[i], lut_valid[i],
            bypass[i], upd_busy[i], err_overrun[i], err_timeout[i]};
  endfunction

  // ---------------- behavioural model (frame-level rules) ----------------
  int  interval[2] = '{1, 3};
  bit  v1[2], v2[2];          // vsync samples one and two clocks ago
  int  eofs[2];               // frame ends seen since reset
  bit  slot[2];
  int  mode[2];               // 0 waiting, 1 filling, 2 table complete
  int  writes[2], idle_run[2];
  bit  bank[2], valid[2], byp[2], m_req[2], m_ovr[2], m_tmo[2];
  bit  m_sof, m_eof, m_acc;

  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        v1[i] = 0; v2[i] = 0; eofs[i] = 0; slot[i] = 0; mode[i] = 0;
        writes[i] = 0; idle_run[i] = 0; bank[i] = 0; valid[i] = 0; byp[i] = 1;
        m_req[i] = 0; m_ovr[i] = 0; m_tmo[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_sof = v1[i] && !v2[i];
        m_eof = !v1[i] && v2[i];
        m_req[i] = 0; m_ovr[i] = 0; m_tmo[i] = 0; m_acc = 0;
        if (mode[i] == 0) begin
          if (stat_ready && slot[i]) begin
            m_req[i] = 1; writes[i] = 0; idle_run[i] = 0; mode[i] = 1; m_acc = 1;
          end else if (stat_ready) begin
            m_ovr[i] = 1;
          end
        end else if (mode[i] == 1) begin
          if (stat_ready) m_ovr[i] = 1;
          if (map_wr_en) begin
            writes[i]++;
            idle_run[i] = 0;
            if (writes[i] == LV) mode[i] = 2;
          end else begin
            idle_run[i]++;
            if (idle_run[i] == TO) begin m_tmo[i] = 1; mode[i] = 0; end
          end
        end else begin
          if (stat_ready) m_ovr[i] = 1;
          if (m_sof) begin bank[i] = !bank[i]; valid[i] = 1; mode[i] = 0; end
        end
        if (m_sof) byp[i] = !(he_en && valid[i]);
        if (m_eof) begin
          slot[i] = (eofs[i] % interval[i]) == 0;
          eofs[i]++;
        end else if (m_acc) begin
          slot[i] = 0;
        end
        v2[i] = v1[i];
        v1[i] = src_vsync;
      end
    end
  end

  // Per-cycle comparison of both instances against the model, plus pulse counts
  always @(negedge pclk) begin
    for (int i = 0; i < 2; i++) begin
      check(i == 0 ? "cycle_dut1" : "cycle_dut3", {24'd0, outs(i)},
            {24'd0, m_req[i], bank[i], !bank[i], valid[i], byp[i], mode[i] != 0, m_ovr[i], m_tmo[i]});
      if (stat_request[i]) req_cnt[i]++;
      if (err_overrun[i])  ovr_cnt[i]++;
      if (err_timeout[i])  tmo_cnt[i]++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic frame(input int len);
    src_vsync = 1'b1;
    idle(len);
    src_vsync = 1'b0;
    idle(4);
  endtask

  task automatic pulse_ready();
    stat_ready = 1'b1;
    tick();
    stat_ready = 1'b0;
  endtask

  task automatic fill(input int n, input int ovr_at);
    for (int w = 0; w < n; w++) begin
      idle($urandom_range(0, 2));
      map_wr_en = 1'b1;
      if (w == ovr_at) stat_ready = 1'b1;
      tick();
      map_wr_en  = 1'b0;
      stat_ready = 1'b0;
      if (w == ovr_at) check("ovr_in_fill", err_overrun[0], 1);
    end
  endtask

  task automatic rnd_cycle(input int wp);
    stat_ready = ($urandom_range(0, 59) == 0);
    map_wr_en  = ($urandom_range(0, 99) < wp);
    if ($urandom_range(0, 299) == 0) he_en = ~he_en;
    tick();
  endtask

  int  base_req, base_ovr, base_tmo, base_req0, base_ovr0;
  logic pre_bank;

  initial begin
    he_en = 1'b1;
    idle(3);
    check("reset_vec", outs(0), 8'b0010_1000);
    rst_n = 1'b1;
    tick();

    // Timeout: 255 writes then silence
    frame(20);
    pulse_ready();
    check("req_timeout_run", stat_request[0], 1);
    base_tmo = tmo_cnt[0];
    fill(255, -1);
    idle(TO + 6);
    check("timeout_pulses", tmo_cnt[0] - base_tmo, 1);
    check("timeout_banks", {wr_bank[0], rd_bank[0]}, 2'b01);
    check("timeout_valid", lut_valid[0], 0);
    frame(20);
    check("timeout_bypass", bypass[0], 1);

    // Three full update frames, overrun injected mid-fill in the second
    base_req0 = req_cnt[0];
    for (int f = 0; f < 3; f++) begin
      pulse_ready();
      check("req_after_ready", stat_request[0], 1);
      fill(LV, f == 1 ? 99 : -1);
      idle(3);
      check("pend_busy", upd_busy[0], 1);
      src_vsync = 1'b1;
      idle(3);
      check("swap_wr_bank", wr_bank[0], (f + 1) & 1);
      check("swap_rd_bank", rd_bank[0], f & 1);
      check("swap_valid", lut_valid[0], 1);
      check("swap_bypass", bypass[0], 0);
      idle(20);
      src_vsync = 1'b0;
      idle(4);
    end
    check("req_count_3frames", req_cnt[0] - base_req0, 3);

    // 256th write lands in the decoded-SOF cycle
    pulse_ready();
    fill(LV - 1, -1);
    idle(2);
    pre_bank  = wr_bank[0];
    src_vsync = 1'b1;
    tick();
    map_wr_en = 1'b1;
    tick();
    map_wr_en = 1'b0;
    idle(2);
    check("coincide_no_swap", wr_bank[0], pre_bank);
    check("coincide_pending", upd_busy[0], 1);
    idle(20);
    src_vsync = 1'b0;
    idle(4);
    src_vsync = 1'b1;
    idle(3);
    check("coincide_late_swap", wr_bank[0], !pre_bank);

    // he_en dropped mid-frame
    idle(5);
    he_en = 1'b0;
    idle(10);
    check("bypass_holds", bypass[0], 0);
    src_vsync = 1'b0;
    idle(4);
    src_vsync = 1'b1;
    idle(3);
    check("bypass_next_sof", bypass[0], 1);
    he_en = 1'b1;
    idle(10);
    src_vsync = 1'b0;
    idle(4);

    // Asynchronous reset in the middle of a fill
    pulse_ready();
    fill(128, -1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_dut1", outs(0), 8'b0010_1000);
    check("async_reset_dut3", outs(1), 8'b0010_1000);
    idle(3);
    rst_n = 1'b1;
    frame(20);
    pulse_ready();
    check("req_after_reset", stat_request[0], 1);
    fill(LV, -1);
    idle(3);
    src_vsync = 1'b1;
    idle(3);
    check("valid_after_reset", {wr_bank[0], lut_valid[0]}, 2'b11);
    idle(10);
    src_vsync = 1'b0;
    idle(4);

    // Interval 3: six frames each followed by a readout attempt
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    tick();
    base_req  = req_cnt[1];
    base_ovr  = ovr_cnt[1];
    base_req0 = req_cnt[0];
    base_ovr0 = ovr_cnt[0];
    for (int f = 1; f <= 6; f++) begin
      frame(20);
      pulse_ready();
      fill(LV, -1);
      idle(3);
    end
    check("int3_accepts", req_cnt[1] - base_req, 2);
    check("int3_overruns", ovr_cnt[1] - base_ovr, 4);
    check("int1_accepts", req_cnt[0] - base_req0, 6);
    check("int1_overruns", ovr_cnt[0] - base_ovr0, 0);

    // Randomised traffic, checked cycle by cycle against the model
    for (int f = 0; f < 20; f++) begin
      int wp;
      int len;
      int vb;
      case ($urandom_range(0, 2))
        0:       wp = 0;
        1:       wp = 50;
        default: wp = 90;
      endcase
      len = $urandom_range(30, 300);
      vb  = $urandom_range(10, 1200);
      src_vsync = 1'b1;
      repeat (len) rnd_cycle(wp);
      src_vsync = 1'b0;
      repeat (vb) rnd_cycle(wp);
    end
    stat_ready = 1'b0;
    map_wr_en  = 1'b0;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
